mem_wb_stage: RTL and testbench

Memory-to-writeback pipeline stage of the 64-bit pipelined RV64I core.
- Registers the instruction leaving MEM and aligns and sign/zero-extends load data.
- Drives the register file write port (`reg_write`, `rd`, `write_data`).
- Exports the same values to the forwarding unit.
- Detects misaligned or illegal loads and holds a trap request until it is acknowledged.
- Maintains the retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 156 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: load alignment/extension, register file write port,
// forwarding copies, load exception capture and the retired-instruction counter.
module mem_wb_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_valid,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_wb_sel,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic [XLEN-1:0] mem_load_raw,
    input  logic [2:0]      mem_funct3,
    input  logic            flush,
    input  logic            exc_ack,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_write_data,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            exc_pending,
    output logic [3:0]      exc_cause,
    output logic [XLEN-1:0] exc_addr,
    output logic [63:0]     instret
);

    typedef enum logic {
        S_IDLE,
        S_PENDING
    } exc_state_e;

    exc_state_e      state_q, state_d;
    logic            valid_q, valid_d;
    logic            reg_write_q;
    logic [4:0]      rd_q;
    logic [1:0]      wb_sel_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] raw_q;
    logic [2:0]      funct3_q;
    logic [3:0]      cause_q, cause_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [63:0]     instret_q, instret_d;

    logic [2:0]      a;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic            misaligned;
    logic            illegal;
    logic            fault;

    assign exc_pending = (state_q == S_PENDING);
    assign valid_d     = mem_valid & ~flush & ~exc_pending;

    // Little-endian lane select: move the addressed byte down to bit 0.
    always_comb begin
        a          = alu_q[2:0];
        shifted    = raw_q >> {a, 3'b000};
        load_data  = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3_q)
            3'b000: load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b100: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b001: begin
                load_data  = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                misaligned = a[0];
            end
            3'b101: begin
                load_data  = {{(XLEN-16){1'b0}}, shifted[15:0]};
                misaligned = a[0];
            end
            3'b010: begin
                load_data  = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
                misaligned = |a[1:0];
            end
            3'b110: begin
                load_data  = {{(XLEN-32){1'b0}}, shifted[31:0]};
                misaligned = |a[1:0];
            end
            3'b011: begin
                load_data  = raw_q;
                misaligned = |a;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign fault = valid_q & (wb_sel_q == 2'b01) & (misaligned | illegal);

    always_comb begin
        wb_reg_write = valid_q & reg_write_q & ~fault & (rd_q != 5'd0);
        wb_rd        = rd_q;
        case (wb_sel_q)
            2'b01:   wb_write_data = load_data;
            2'b10:   wb_write_data = pc4_q;
            default: wb_write_data = alu_q;
        endcase
    end

    assign fwd_valid = wb_reg_write;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_write_data;
    assign exc_cause = cause_q;
    assign exc_addr  = addr_q;
    assign instret   = instret_q;

    // A fault arriving with the ack replaces the old cause instead of clearing.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        addr_d    = addr_q;
        instret_d = instret_q + 64'(valid_q & ~fault);
        if (fault && (state_q == S_IDLE || exc_ack)) begin
            state_d = S_PENDING;
            cause_d = illegal ? 4'd2 : 4'd4;
            addr_d  = alu_q;
        end else if (state_q == S_PENDING && exc_ack) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_sel_q    <= '0;
            alu_q       <= '0;
            pc4_q       <= '0;
            raw_q       <= '0;
            funct3_q    <= '0;
            cause_q     <= '0;
            addr_q      <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            reg_write_q <= mem_reg_write;
            rd_q        <= mem_rd;
            wb_sel_q    <= mem_wb_sel;
            alu_q       <= mem_alu_result;
            pc4_q       <= mem_pc_plus4;
            raw_q       <= mem_load_raw;
            funct3_q    <= mem_funct3;
            cause_q     <= cause_d;
            addr_q      <= addr_d;
            instret_q   <= instret_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: each step pushes its expected WB view to a
// scoreboard queue and pops it once the DUT has captured the instruction.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [63:0] mem_alu_result, mem_pc_plus4, mem_load_raw;
    logic [2:0]  mem_funct3;
    logic        flush, exc_ack;
    logic        wb_reg_write, fwd_valid, exc_pending;
    logic [4:0]  wb_rd, fwd_rd;
    logic [63:0] wb_write_data, fwd_data, exc_addr, instret;
    logic [3:0]  exc_cause;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel),
        .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
        .mem_load_raw(mem_load_raw), .mem_funct3(mem_funct3),
        .flush(flush), .exc_ack(exc_ack),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_write_data(wb_write_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .exc_pending(exc_pending), .exc_cause(exc_cause),
        .exc_addr(exc_addr), .instret(instret)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] ret;
        logic        pend;
        logic [3:0]  cause;
        logic [63:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;
    logic [63:0] exp_ret = '0;
    logic        last_inc = 1'b0;

    localparam logic [63:0] R = 64'h8877665544332211;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL step %0d %s: got %h want %h", step_no, tag, obs, exp);
        end
    endtask

    task automatic step(
        input logic v, input logic rw, input logic [4:0] rd,
        input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] pc4,
        input logic [63:0] raw, input logic [2:0] f3,
        input logic fl, input logic ack,
        input logic e_we, input logic [63:0] e_data, input logic inc,
        input logic e_pend, input logic [3:0] e_cause, input logic [63:0] e_addr);
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
        mem_alu_result = alu; mem_pc_plus4 = pc4; mem_load_raw = raw;
        mem_funct3 = f3; flush = fl; exc_ack = ack;
        // the previous step's instruction retires on this coming edge
        exp_ret  = exp_ret + 64'(last_inc);
        last_inc = inc;
        e.we = e_we; e.rd = rd; e.data = e_data; e.ret = exp_ret;
        e.pend = e_pend; e.cause = e_cause; e.addr = e_addr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        e = sb.pop_front();
        chk("wb_reg_write", 64'(wb_reg_write), 64'(e.we));
        chk("fwd_valid", 64'(fwd_valid), 64'(e.we));
        if (e.we) begin
            chk("wb_rd", 64'(wb_rd), 64'(e.rd));
            chk("wb_write_data", wb_write_data, e.data);
            chk("fwd_data", fwd_data, e.data);
        end
        chk("instret", instret, e.ret);
        chk("exc_pending", 64'(exc_pending), 64'(e.pend));
        if (e.pend) begin
            chk("exc_cause", 64'(exc_cause), 64'(e.cause));
            chk("exc_addr", exc_addr, e.addr);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd4;
        mem_wb_sel = 2'b00; mem_alu_result = 64'hDEAD; mem_pc_plus4 = 64'h4;
        mem_load_raw = R; mem_funct3 = 3'b011; flush = 1'b0; exc_ack = 1'b0;
        @(posedge clk);
        #1;
        step_no++;
        chk("rst wb_reg_write", 64'(wb_reg_write), 64'd0);
        chk("rst wb_rd", 64'(wb_rd), 64'd0);
        chk("rst wb_write_data", wb_write_data, 64'd0);
        chk("rst fwd_valid", 64'(fwd_valid), 64'd0);
        chk("rst fwd_rd", 64'(fwd_rd), 64'd0);
        chk("rst fwd_data", fwd_data, 64'd0);
        chk("rst exc_pending", 64'(exc_pending), 64'd0);
        chk("rst exc_cause", 64'(exc_cause), 64'd0);
        chk("rst exc_addr", exc_addr, 64'd0);
        chk("rst instret", instret, 64'd0);
        exp_ret  = '0;
        last_inc = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        do_reset();
        do_reset();
        // ALU writeback and load extraction
        step(1,1,5,2'b00,64'h1234,0,R,3'b000,0,0, 1,64'h1234,1, 0,0,0);
        step(1,1,6,2'b01,64'h7,0,R,3'b000,0,0, 1,64'hFFFFFFFFFFFFFF88,1, 0,0,0);
        step(1,1,7,2'b01,64'h6,0,R,3'b101,0,0, 1,64'h8877,1, 0,0,0);
        step(1,1,8,2'b01,64'h4,0,R,3'b010,0,0, 1,64'hFFFFFFFF88776655,1, 0,0,0);
        step(1,1,9,2'b01,64'h4,0,R,3'b110,0,0, 1,64'h88776655,1, 0,0,0);
        step(1,1,10,2'b01,64'h0,0,R,3'b011,0,0, 1,R,1, 0,0,0);
        // JAL to x0, then JAL to x1
        step(1,1,0,2'b10,64'h0,64'h80000004,R,3'b000,0,0, 0,0,1, 0,0,0);
        step(1,1,1,2'b10,64'h0,64'h80000008,R,3'b000,0,0, 1,64'h80000008,1, 0,0,0);
        // misaligned LW, dropped ADD, ack, ADD writes back
        step(1,1,11,2'b01,64'h1002,0,R,3'b010,0,0, 0,0,0, 0,0,0);
        step(0,0,0,2'b00,64'h0,0,R,3'b000,0,0, 0,0,0, 1,4'd4,64'h1002);
        step(1,1,12,2'b00,64'h55,0,R,3'b000,0,0, 0,0,0, 1,4'd4,64'h1002);
        step(0,0,0,2'b00,64'h0,0,R,3'b000,0,1, 0,0,0, 0,0,0);
        step(1,1,12,2'b00,64'h55,0,R,3'b000,0,0, 1,64'h55,1, 0,0,0);
        // illegal funct3, then ack colliding with a misaligned LH
        step(1,1,13,2'b01,64'h2000,0,R,3'b111,0,0, 0,0,0, 0,0,0);
        step(1,1,14,2'b01,64'h3,0,R,3'b001,0,0, 0,0,0, 1,4'd2,64'h2000);
        step(0,0,0,2'b00,64'h0,0,R,3'b000,0,1, 0,0,0, 1,4'd4,64'h3);
        step(0,0,0,2'b00,64'h0,0,R,3'b000,0,1, 0,0,0, 0,0,0);
        step(0,0,0,2'b00,64'h0,0,R,3'b000,0,1, 0,0,0, 0,0,0);
        // flush beats mem_valid
        step(1,1,15,2'b00,64'h77,0,R,3'b000,1,0, 0,0,0, 0,0,0);
        step(1,1,16,2'b00,64'h99,0,R,3'b000,0,0, 1,64'h99,1, 0,0,0);
        for (int i = 0; i < 6; i++) begin
            step(1,0,5'(17+i),2'b00,64'(i),0,R,3'b000,0,0, 0,0,1, 0,0,0);
        end
        // instret reaches 0x10, then a fault leaves an exception pending
        step(1,1,23,2'b01,64'h1,0,R,3'b010,0,0, 0,0,0, 0,0,0);
        step(0,0,0,2'b00,64'h0,0,R,3'b000,0,0, 0,0,0, 1,4'd4,64'h1);
        chk("instret pre-reset", instret, 64'h10);
        do_reset();
        step(1,1,3,2'b00,64'hAB,0,R,3'b000,0,0, 1,64'hAB,1, 0,0,0);
        step(0,0,0,2'b00,64'h0,0,R,3'b000,0,0, 0,0,0, 0,0,0);
        chk("instret after release", instret, 64'd1);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
